alu4_accumulator_reg: RTL

//  Registered accumulator stage directly downstream of the 4-bit ALU.
//  - Captures the ALU's 8-bit result unless the ALU asserts its hold flag.
//  - Feeds acc[3:0] back to the ALU B operand.
//  - Presents the stored value to a downstream consumer (HEX display or logger)

---
 rtl/alu4_accumulator_reg_pkg.sv | 35 +++
 rtl/alu4_accumulator_reg_sat_counter.sv | 29 ++
 rtl/alu4_accumulator_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/alu4_accumulator_reg_pkg.sv
// Shared definitions for the ALU accumulator stage.
//   - Default widths, shared with the upstream 4-bit ALU.
//   - FSM state encoding. 2'b11 is unused and decodes to EMPTY.
//   - next_state(): the state update applied on each clock edge.
package alu4_accumulator_reg_pkg;

  localparam int DATA_W_DEF = 8;  // ALU result / accumulator width
  localparam int FB_W_DEF   = 4;  // feedback slice to ALU operand B
  localparam int CNT_W_DEF  = 8;  // event counter width

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,  // no value since reset/clear
    ST_ACTIVE = 2'b01,  // last accept was an update
    ST_HOLD   = 2'b10   // last accept was a hold
  } state_t;

  // The state moves only on an accept. The one exception is an
  // unused encoding, which falls back to EMPTY on the next edge.
  // Clear is handled by the caller, ahead of this function.
  function automatic state_t next_state(input state_t cur,
                                        input logic   upd,
                                        input logic   hld);
    state_t nxt;
    if (upd)      nxt = ST_ACTIVE;
    else if (hld) nxt = ST_HOLD;
    else begin
      case (cur)
        ST_EMPTY, ST_ACTIVE, ST_HOLD: nxt = cur;
        default:                      nxt = ST_EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu4_accumulator_reg_sat_counter.sv
// Saturating event counter.
//   - Counts inc pulses.
//   - Stops at all-ones; it never wraps.
//   - clr is a synchronous clear and takes priority over inc.
// Ports:
//   clk    in  1      rising-edge clock
//   resetn in  1      asynchronous active-low reset
//   clr    in  1      synchronous clear
//   inc    in  1      count one event
//   q      out CNT_W  current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + ONE;
  end

endmodule

// File: rtl/alu4_accumulator_reg.sv
// Registered accumulator stage placed after the 4-bit ALU.
//   - Captures alu_out on an accept, unless acc_hold is set.
//   - Feeds acc_q[FB_W-1:0] back to ALU operand B.
//   - Presents acc_q downstream over a valid/ready handshake.
// Ports:
//   clk       in  1       rising-edge clock
//   resetn    in  1       asynchronous active-low reset
//   clear     in  1       sync clear of accumulator, valid and counters
//   in_valid  in  1       alu_out/acc_hold valid this cycle
//   in_ready  out 1       stage accepts the ALU result this cycle
//   alu_out   in  DATA_W  ALU result
//   acc_hold  in  1       1 = keep the current accumulator (counted as a hold)
//   acc_q     out DATA_W  accumulator
//   acc_b     out FB_W    low slice of acc_q, fed back to the ALU
//   out_valid out 1       acc_q holds a new, unconsumed value
//   out_ready in  1       downstream takes acc_q when out_valid=1
//   state_o   out 2       FSM state: 00 EMPTY, 01 ACTIVE, 10 HOLD
//   upd_cnt   out CNT_W   accepted updates, saturating
//   hold_cnt  out CNT_W   accepted holds, saturating
module alu4_accumulator_reg
  import alu4_accumulator_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FB_W   = FB_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              acc_hold,
  output logic [DATA_W-1:0] acc_q,
  output logic [FB_W-1:0]   acc_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  upd_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);

  state_t state;
  logic   accept;
  logic   upd;
  logic   hld;

  // A pending value blocks new input, so acc_q cannot change under an
  // unconsumed value. Clear wins over any same-cycle input.
  assign in_ready = ~clear & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign upd      = accept & ~acc_hold;
  assign hld      = accept &  acc_hold;

  assign acc_b    = acc_q[FB_W-1:0];
  assign state_o  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      state     <= ST_EMPTY;
    end else if (clear) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      state     <= ST_EMPTY;
    end else begin
      if (upd) acc_q <= alu_out;
      // A new update outranks a same-cycle consume. A hold neither sets
      // nor clears out_valid.
      if (upd)            out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      state <= next_state(state, upd, hld);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_upd_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .inc    (upd),
    .q      (upd_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .inc    (hld),
    .q      (hold_cnt)
  );

endmodule
